// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU encodings: opcodes, condition codes, flag bit
//               positions and the return-address register index.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Opcodes that the PC stage decodes
  localparam logic [3:0] OP_JCOND = 4'b0011;
  localparam logic [3:0] OP_JAL   = 4'b1100;

  // Condition codes carried in instr[11:8]
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Bit positions inside the registered flag vector {C,L,F,Z,N}
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // Register used as the return-address register by JUC
  localparam logic [3:0] RET_REG = 4'hF;

endpackage
`default_nettype wire

// File: rtl/pc_branch_unit_ras_stack.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack
// Description : Return-address LIFO held in a circular buffer. A push when
//               full overwrites the oldest entry; a pop when empty is ignored.
//               Overflow/underflow are single-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CNT_W-1:0] depth_o,
  output logic             empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;   // next write slot; top lives at ptr_q-1
  logic [CNT_W-1:0] cnt_q;
  logic             w_full;
  logic [PTR_W-1:0] w_top_idx;

  assign w_full      = (cnt_q == CNT_W'(DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign w_top_idx   = ptr_q - PTR_W'(1);
  assign top_o       = mem_q[w_top_idx];
  assign depth_o     = cnt_q;
  // Because the buffer is circular, writing at ptr_q when full lands on the
  // oldest entry, which is exactly the drop-oldest behaviour wanted.
  assign overflow_o  = push_i & w_full;
  assign underflow_o = pop_i & empty_o;

  // Stack storage, pointer and occupancy update
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i) begin
      mem_q[ptr_q] <= data_i;
      ptr_q        <= ptr_q + PTR_W'(1);
      if (!w_full) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (pop_i && !empty_o) begin
      ptr_q <= ptr_q - PTR_W'(1);
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_branch_unit
// Description : Program-counter stage. Sequential increment, conditional
//               jumps, JAL with link capture, and a return-address stack that
//               short-circuits JUC r15. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_branch_unit
  import cpu_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              jump_sel,
  input  logic [15:0]       instr,
  input  logic [4:0]        flags,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              taken,
  output logic [2:0]        ras_depth,
  output logic              ras_err
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] link_q, link_d;
  logic              taken_q, taken_d;
  logic              err_q, err_d;

  logic [3:0]        w_opcode;
  logic [3:0]        w_cond;
  logic [3:0]        w_rtarget;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_ras_top;
  logic [CNT_W-1:0]  w_ras_cnt;
  logic              w_ras_empty;
  logic              w_ras_ovf;
  logic              w_ras_unf;
  logic              w_unused_bits;

  assign w_opcode      = instr[15:12];
  assign w_cond        = instr[11:8];
  assign w_rtarget     = instr[3:0];
  assign w_unused_bits = ^instr[7:4];
  assign w_pc_inc      = pc_q + ADDR_W'(1);

  // Condition-code evaluation against the flags of the current cycle
  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
    logic r;
    r = 1'b0;
    case (c)
      COND_EQ: r =  f[FLAG_Z];
      COND_NE: r = !f[FLAG_Z];
      COND_CS: r =  f[FLAG_C];
      COND_CC: r = !f[FLAG_C];
      COND_HI: r =  f[FLAG_L];
      COND_LS: r = !f[FLAG_L];
      COND_GT: r =  f[FLAG_N];
      COND_LE: r = !f[FLAG_N];
      COND_FS: r =  f[FLAG_F];
      COND_FC: r = !f[FLAG_F];
      COND_LO: r = !f[FLAG_L] & !f[FLAG_Z];
      COND_HS: r =  f[FLAG_L] |  f[FLAG_Z];
      COND_LT: r = !f[FLAG_N] & !f[FLAG_Z];
      COND_GE: r =  f[FLAG_N] |  f[FLAG_Z];
      COND_UC: r = 1'b1;
      COND_NV: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W),
    .CNT_W (CNT_W)
  ) u_ras (
    .clock       (clock),
    .reset       (reset),
    .push_i      (w_push),
    .pop_i       (w_pop),
    .data_i      (w_pc_inc),
    .top_o       (w_ras_top),
    .depth_o     (w_ras_cnt),
    .empty_o     (w_ras_empty),
    .overflow_o  (w_ras_ovf),
    .underflow_o (w_ras_unf)
  );

  // Next-PC selection, link capture and RAS push/pop decode
  always_comb begin
    pc_d    = pc_q;
    link_d  = link_q;
    taken_d = taken_q;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    if (pc_en) begin
      pc_d    = w_pc_inc;
      taken_d = 1'b0;
      if (jump_sel) begin
        case (w_opcode)
          OP_JCOND: begin
            if (cond_true(w_cond, flags)) begin
              taken_d = 1'b1;
              if (w_cond == COND_UC && w_rtarget == RET_REG) begin
                // Return: prefer the stacked address, fall back to r15
                w_pop = 1'b1;
                pc_d  = w_ras_empty ? reg_target : w_ras_top;
              end else begin
                pc_d = reg_target;
              end
            end
          end
          OP_JAL: begin
            pc_d    = reg_target;
            link_d  = w_pc_inc;
            w_push  = 1'b1;
            taken_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
    // Push and pop are mutually exclusive by opcode, so at most one pulses
    err_d = err_q | w_ras_ovf | w_ras_unf;
  end

  // Architectural PC-stage registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q    <= RESET_VEC;
      link_q  <= '0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      link_q  <= link_d;
      taken_q <= taken_d;
      err_q   <= err_d;
    end
  end

  assign pc        = pc_q;
  assign link_addr = link_q;
  assign taken     = taken_q;
  assign ras_err   = err_q;
  assign ras_depth = 3'(w_ras_cnt);

endmodule
`default_nettype wire
